// File: rtl/ysyx_24120013_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_24120013_ifu_pkg;

    localparam int unsigned IFU_ADDR_WIDTH = 32;
    localparam int unsigned IFU_DATA_WIDTH = 32;
    localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
    localparam int unsigned IFU_PC_INC     = 4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ysyx_24120013_ifu_if.sv
// Memory request/response, decode handoff and redirect signals of the fetch unit.
interface ysyx_24120013_ifu_if
    import ysyx_24120013_ifu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = IFU_DATA_WIDTH
);

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;
    logic                  mem_rsp_err;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  fetch_err;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    // Fetch unit side
    modport ifu (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output inst_valid, inst, inst_pc, fetch_err,
        input  inst_ready,
        input  redirect_valid, redirect_pc
    );

    // Memory, decode and execute side
    modport env (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  inst_valid, inst, inst_pc, fetch_err,
        output inst_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ysyx_24120013_pc_reg.sv
// PC register: redirect (word-aligned) beats sequential increment beats hold.
module ysyx_24120013_pc_reg
    import ysyx_24120013_ifu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;

    // Next-PC select; increment wraps modulo 2^ADDR_WIDTH
    always_comb begin
        w_pc_nxt = r_pc;
        if (i_redirect) begin
            w_pc_nxt = i_redirect_pc & ALIGN_MASK;
        end else if (i_inc) begin
            w_pc_nxt = r_pc + ADDR_WIDTH'(IFU_PC_INC);
        end
    end

    // PC state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_24120013_ifu.sv
// Instruction fetch unit: one memory read per instruction, held for decode, redirect-aware.
module ysyx_24120013_ifu
    import ysyx_24120013_ifu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = IFU_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_24120013_ifu_if.ifu     ifu_bus
);

    ifu_state_e            r_state;
    ifu_state_e            w_state_nxt;
    logic                  r_kill;
    logic                  w_kill_nxt;
    logic                  r_run;
    logic                  w_req_fire;
    logic                  w_latch;
    logic                  w_pc_inc;
    logic [ADDR_WIDTH-1:0] w_pc;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [ADDR_WIDTH-1:0] r_inst_pc;
    logic                  r_fetch_err;

    ysyx_24120013_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .i_redirect    (ifu_bus.redirect_valid),
        .i_redirect_pc (ifu_bus.redirect_pc),
        .i_inc         (w_pc_inc),
        .o_pc          (w_pc)
    );

    // r_run keeps the request off during reset and the first edge after it
    assign w_req_fire = r_run && (r_state == ST_REQ) && ifu_bus.mem_req_ready;

    // State, kill flag and run flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_REQ;
            r_kill  <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
            r_run   <= 1'b1;
        end
    end

    // Next-state: kill marks the one in-flight response to be dropped
    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_latch     = 1'b0;
        w_pc_inc    = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = ST_WAIT;
                    if (ifu_bus.redirect_valid) begin
                        w_kill_nxt = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (ifu_bus.mem_rsp_valid) begin
                    w_kill_nxt = 1'b0;
                    if (r_kill || ifu_bus.redirect_valid) begin
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (ifu_bus.redirect_valid) begin
                    w_kill_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ifu_bus.redirect_valid) begin
                    w_state_nxt = ST_REQ;
                end else if (ifu_bus.inst_ready) begin
                    w_pc_inc    = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
                w_kill_nxt  = 1'b0;
            end
        endcase
    end

    // Held instruction, captured only from a live response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst      <= '0;
            r_inst_pc   <= '0;
            r_fetch_err <= 1'b0;
        end else if (w_latch) begin
            r_inst      <= ifu_bus.mem_rsp_data;
            r_inst_pc   <= w_pc;
            r_fetch_err <= ifu_bus.mem_rsp_err;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        ifu_bus.mem_req_valid = r_run && (r_state == ST_REQ);
        ifu_bus.mem_req_addr  = w_pc;
        ifu_bus.inst_valid    = (r_state == ST_HOLD);
        ifu_bus.inst          = r_inst;
        ifu_bus.inst_pc       = r_inst_pc;
        ifu_bus.fetch_err     = r_fetch_err;
    end

    // Response outside WAIT is a memory protocol violation; it is ignored
    always_ff @(posedge clk) begin
        if (rst && ifu_bus.mem_rsp_valid) begin
            assert (r_state == ST_WAIT)
            else $warning("ifu: mem_rsp_valid outside WAIT ignored");
        end
    end

endmodule

// File: tb/tb_ysyx_24120013_ifu.sv
// Directed cycle-scripted bench for the instruction fetch unit.
module tb_ysyx_24120013_ifu;
    import ysyx_24120013_ifu_pkg::*;

    logic        clk;
    logic        rst;
    int unsigned n_checks;
    int unsigned n_fail;

    ysyx_24120013_ifu_if #(
        .ADDR_WIDTH (IFU_ADDR_WIDTH),
        .DATA_WIDTH (IFU_DATA_WIDTH)
    ) ifu_bus ();

    ysyx_24120013_ifu dut (
        .clk     (clk),
        .rst     (rst),
        .ifu_bus (ifu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the script stalls
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic act, input logic exp);
        check_eq(tag, 32'(act), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d, input logic e);
        ifu_bus.mem_rsp_valid = v;
        ifu_bus.mem_rsp_data  = d;
        ifu_bus.mem_rsp_err   = e;
    endtask

    task automatic redir(input logic v, input logic [31:0] pc);
        ifu_bus.redirect_valid = v;
        ifu_bus.redirect_pc    = pc;
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
        check_bit({tag, "_req_valid"}, ifu_bus.mem_req_valid, v);
        if (v) check_eq({tag, "_req_addr"}, ifu_bus.mem_req_addr, addr);
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] w, input logic [31:0] pc, input logic e);
        check_bit({tag, "_inst_valid"}, ifu_bus.inst_valid, 1'b1);
        check_eq({tag, "_inst"}, ifu_bus.inst, w);
        check_eq({tag, "_inst_pc"}, ifu_bus.inst_pc, pc);
        check_bit({tag, "_fetch_err"}, ifu_bus.fetch_err, e);
    endtask

    task automatic chk_reset_outs(input string tag);
        check_bit({tag, "_req_valid"}, ifu_bus.mem_req_valid, 1'b0);
        check_bit({tag, "_inst_valid"}, ifu_bus.inst_valid, 1'b0);
        check_eq({tag, "_inst"}, ifu_bus.inst, 32'h0);
        check_eq({tag, "_inst_pc"}, ifu_bus.inst_pc, 32'h0);
        check_bit({tag, "_fetch_err"}, ifu_bus.fetch_err, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        ifu_bus.mem_req_ready = 1'b1;
        ifu_bus.inst_ready    = 1'b1;
        rsp(1'b0, 32'h0, 1'b0);
        redir(1'b0, 32'h0);

        // Reset state
        step();
        step();
        chk_reset_outs("rst0");
        rst = 1'b1;

        // Zero-wait fetch: request cycle 1, response cycle 2, inst cycle 3
        step();
        chk_req("c1", 1'b1, 32'h8000_0000);
        step();
        chk_req("c2", 1'b0, 32'h0);
        check_bit("c2_inst_valid", ifu_bus.inst_valid, 1'b0);
        rsp(1'b1, 32'h0010_0093, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        chk_inst("c3", 32'h0010_0093, 32'h8000_0000, 1'b0);
        step();
        chk_req("c4", 1'b1, 32'h8000_0004);

        // Decode backpressure for 5 cycles
        ifu_bus.inst_ready = 1'b0;
        step();
        rsp(1'b1, 32'h0020_0113, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk_inst("bp", 32'h0020_0113, 32'h8000_0004, 1'b0);
            chk_req("bp", 1'b0, 32'h0);
            step();
        end
        check_bit("bp_end_inst_valid", ifu_bus.inst_valid, 1'b1);
        ifu_bus.inst_ready = 1'b1;
        step();
        chk_req("bp_next", 1'b1, 32'h8000_0008);

        // Redirect during WAIT, stale response dropped
        step();
        redir(1'b1, 32'h8000_0100);
        step();
        redir(1'b0, 32'h0);
        chk_req("rw_wait", 1'b0, 32'h0);
        rsp(1'b1, 32'hDEAD_BEEF, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        check_bit("rw_inst_valid", ifu_bus.inst_valid, 1'b0);
        chk_req("rw_next", 1'b1, 32'h8000_0100);

        // Redirect coincident with request acceptance
        redir(1'b1, 32'h8000_0203);
        step();
        redir(1'b0, 32'h0);
        chk_req("rr_wait", 1'b0, 32'h0);
        rsp(1'b1, 32'h1111_1111, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        check_bit("rr_inst_valid", ifu_bus.inst_valid, 1'b0);
        chk_req("rr_next", 1'b1, 32'h8000_0200);

        // Redirect while request is unacknowledged
        ifu_bus.mem_req_ready = 1'b0;
        redir(1'b1, 32'h8000_0008);
        step();
        redir(1'b0, 32'h0);
        ifu_bus.mem_req_ready = 1'b1;
        chk_req("rq", 1'b1, 32'h8000_0008);

        // Access fault at 8000_0008, then clean fetch at 8000_000C
        step();
        rsp(1'b1, 32'h0000_0073, 1'b1);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        chk_inst("err", 32'h0000_0073, 32'h8000_0008, 1'b1);
        step();
        chk_req("err_next", 1'b1, 32'h8000_000C);
        step();
        rsp(1'b1, 32'h0030_0193, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        chk_inst("clean", 32'h0030_0193, 32'h8000_000C, 1'b0);
        step();
        chk_req("clean_next", 1'b1, 32'h8000_0010);

        // PC wraps at the top of the address space
        ifu_bus.mem_req_ready = 1'b0;
        redir(1'b1, 32'hFFFF_FFFC);
        step();
        redir(1'b0, 32'h0);
        ifu_bus.mem_req_ready = 1'b1;
        chk_req("wrap_top", 1'b1, 32'hFFFF_FFFC);
        step();
        rsp(1'b1, 32'h0000_0013, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        chk_inst("wrap", 32'h0000_0013, 32'hFFFF_FFFC, 1'b0);
        step();
        chk_req("wrap_next", 1'b1, 32'h0000_0000);

        // Redirect in HOLD with inst_ready high: pc takes the target
        step();
        rsp(1'b1, 32'hAAAA_5555, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        chk_inst("rh", 32'hAAAA_5555, 32'h0000_0000, 1'b0);
        redir(1'b1, 32'h8000_0040);
        step();
        redir(1'b0, 32'h0);
        check_bit("rh_inst_valid", ifu_bus.inst_valid, 1'b0);
        chk_req("rh_next", 1'b1, 32'h8000_0040);

        // Reset mid-WAIT, late response after release
        step();
        chk_req("mr_wait", 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        chk_reset_outs("mr_async");
        step();
        chk_reset_outs("mr_hold");
        rst = 1'b1;
        rsp(1'b1, 32'h0BAD_C0DE, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        check_bit("mr_inst_valid", ifu_bus.inst_valid, 1'b0);
        chk_req("mr_restart", 1'b1, 32'h8000_0000);
        step();
        rsp(1'b1, 32'h0010_0093, 1'b0);
        step();
        rsp(1'b0, 32'h0, 1'b0);
        chk_inst("mr_fetch", 32'h0010_0093, 32'h8000_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
